// File: rtl/mul_8x8.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Latency: WIDTH work cycles after the accepting edge; busy_o is high for exactly WIDTH cycles.
// Backpressure: start_i is a level request sampled only in IDLE; inputs are ignored while busy.
module mul_8x8 #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]   b_bi,
    input  logic               start_i,
    output logic               busy_o,
    output logic [2*WIDTH-1:0] y_bo
);

    // Counter wide enough to index every multiplier bit (at least one bit).
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CTR_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WORK = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      ctr;

    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;
    logic               ctr_last;

    // Partial product for the current bit and the single shared adder.
    always_comb begin
        addend   = '0;
        if (b_r[ctr]) begin
            addend = {{WIDTH{1'b0}}, a_r} << ctr;
        end
        acc_next = acc + addend;
        ctr_last = (ctr == CTR_LAST);
    end

    // Control FSM with registered busy/result; the result register only
    // changes at completion, so partial sums are never visible on y_bo.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            ctr    <= '0;
            busy_o <= 1'b0;
            y_bo   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        a_r    <= a_bi;
                        b_r    <= b_bi;
                        acc    <= '0;
                        ctr    <= '0;
                        busy_o <= 1'b1;
                        state  <= S_WORK;
                    end
                end
                S_WORK: begin
                    acc <= acc_next;
                    ctr <= ctr + CW'(1);
                    if (ctr_last) begin
                        y_bo   <= acc_next;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_8x8.sv
// Bench for mul_8x8: directed operands, expected products queued at issue time,
// a negedge monitor pops and compares whenever busy_o falls.
module tb_mul_8x8;

    localparam int WIDTH = 8;

    logic              clk_i   = 1'b0;
    logic              rst_i   = 1'b0;
    logic [WIDTH-1:0]  a_bi    = '0;
    logic [WIDTH-1:0]  b_bi    = '0;
    logic              start_i = 1'b0;
    logic              busy_o;
    logic [2*WIDTH-1:0] y_bo;

    mul_8x8 #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [2*WIDTH-1:0] sb[$];
    logic [2*WIDTH-1:0] last_y = '0;
    logic [2*WIDTH-1:0] exp_v;
    logic               prev_busy = 1'b0;
    int                 busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: result must hold between completions and update exactly when busy falls.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
            last_y    = '0;
        end else begin
            if (busy_o) begin
                busy_cnt++;
                check("y_hold_while_busy", 32'(y_bo), 32'(last_y));
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got %0d with no expected entry", y_bo);
                end else begin
                    exp_v = sb.pop_front();
                    check("product", 32'(y_bo), 32'(exp_v));
                    check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
                    last_y = exp_v;
                end
                busy_cnt = 0;
            end else begin
                check("y_hold_idle", 32'(y_bo), 32'(last_y));
            end
            prev_busy = busy_o;
        end
    end

    // Waits for IDLE, presents operands with start high, and queues the product.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold_start);
        int t = 0;
        @(negedge clk_i);
        while (busy_o && t < 25) begin
            @(negedge clk_i);
            t++;
        end
        if (busy_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy_o=%0d after %0d cycles, expected 0", busy_o, t);
        end
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        sb.push_back((2*WIDTH)'(a) * (2*WIDTH)'(b));
        @(posedge clk_i);
        #1;
        if (!hold_start) start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk_i);
        while (busy_o && t < 25) begin
            @(negedge clk_i);
            t++;
        end
        if (busy_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: busy_o=%0d after %0d cycles, expected 0", busy_o, t);
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #23;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_y", 32'(y_bo), 32'd0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;

        // Zero operands.
        issue(8'd0, 8'd0, 1'b0);
        wait_idle();

        // Squares 0..15, start held high between operations.
        for (int i = 0; i < 16; i++) begin
            issue(WIDTH'(i), WIDTH'(i), (i != 15));
        end
        wait_idle();

        // Full-range and small products.
        issue(8'd255, 8'd255, 1'b0);
        issue(8'd3, 8'd5, 1'b0);
        wait_idle();

        // Operand change mid-operation must not disturb 7*9.
        issue(8'd7, 8'd9, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        a_bi = 8'd200;
        b_bi = 8'd200;
        wait_idle();
        check("mid_change_result", 32'(y_bo), 32'd63);
        issue(8'd200, 8'd200, 1'b0);
        wait_idle();
        check("next_start_result", 32'(y_bo), 32'd40000);

        // Asynchronous reset in the middle of an operation.
        issue(8'd100, 8'd50, 1'b0);
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        sb.delete();
        #1;
        check("async_reset_busy", 32'(busy_o), 32'd0);
        check("async_reset_y", 32'(y_bo), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        issue(8'd12, 8'd13, 1'b0);
        wait_idle();
        check("after_reset_result", 32'(y_bo), 32'd156);

        // Single-cycle start pulse: exactly one operation, then y_bo holds.
        issue(8'd11, 8'd11, 1'b0);
        wait_idle();
        repeat (12) @(negedge clk_i);
        check("pulse_busy_low", 32'(busy_o), 32'd0);
        check("pulse_y_hold", 32'(y_bo), 32'd121);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
